// File: rtl/dp_job_issuer_if.sv
// Peripheral-master bus between the job issuer and the accelerator register window.
interface dp_job_issuer_if;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/dp_job_issuer.sv
// Issues one accelerator job: acquire a job slot, write the parameter words,
// trigger, then wait for the completion event (optionally with a timeout).
module dp_job_issuer #(
  parameter int unsigned N_PARAMS    = 29,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_RETRY   = 16,
  parameter int unsigned EVT_TIMEOUT = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      job_valid_i,
  input  logic [N_PARAMS-1:0][31:0] job_params_i,
  output logic                      job_ready_o,
  dp_job_issuer_if.master           periph,
  input  logic                      evt_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [7:0]                job_id_o
);
  localparam int unsigned IW = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = (EVT_TIMEOUT > 0) ? $clog2(EVT_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_PARAMS - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(EVT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACQ, S_ACQ_WAIT, S_WR_PARAM, S_TRIGGER, S_WAIT_EVT, S_FINISH
  } state_e;

  state_e                    state_q, state_d;
  logic [N_PARAMS-1:0][31:0] pbuf_q, pbuf_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [RW-1:0]             rcnt_q, rcnt_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic [7:0]                id_q, id_d;
  logic                      err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pbuf_q  <= '0;
      idx_q   <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pbuf_q  <= pbuf_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pbuf_d  = pbuf_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    id_d    = id_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (job_valid_i) begin
        pbuf_d  = job_params_i;
        rcnt_d  = '0;
        state_d = S_ACQ;
      end
      S_ACQ: if (periph.gnt) state_d = S_ACQ_WAIT;
      S_ACQ_WAIT: if (periph.r_valid) begin
        // All-ones read back means the accelerator has no free job slot
        if (periph.r_data == 32'hFFFF_FFFF) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == RTY_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ACQ;
          end
        end else begin
          id_d    = periph.r_data[7:0];
          idx_d   = '0;
          state_d = S_WR_PARAM;
        end
      end
      S_WR_PARAM: if (periph.gnt) begin
        if (idx_q == IDX_LAST) state_d = S_TRIGGER;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_TRIGGER: if (periph.gnt) begin
        tcnt_d  = '0;
        state_d = S_WAIT_EVT;
      end
      S_WAIT_EVT: begin
        if (evt_i) begin
          state_d = S_FINISH;
        end else if (EVT_TIMEOUT != 0) begin
          if (tcnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    periph.req  = 1'b0;
    periph.wen  = 1'b1;
    periph.be   = 4'hF;
    periph.add  = '0;
    periph.data = '0;
    case (state_q)
      S_ACQ: begin
        periph.req = 1'b1;
        periph.add = BASE_ADDR + 32'h04;
      end
      S_WR_PARAM: begin
        periph.req  = 1'b1;
        periph.wen  = 1'b0;
        periph.add  = BASE_ADDR + 32'h40 + (32'(idx_q) << 2);
        periph.data = pbuf_q[idx_q];
      end
      S_TRIGGER: begin
        periph.req = 1'b1;
        periph.wen = 1'b0;
        periph.add = BASE_ADDR;
      end
      default: ;
    endcase
    busy_o      = (state_q != S_IDLE);
    job_ready_o = (state_q == S_IDLE) && rst_ni;
    done_o      = (state_q == S_FINISH);
    err_o       = err_q;
    job_id_o    = id_q;
  end
endmodule

// File: doc/dp_job_issuer.md
DP_JOB_ISSUER -- requirements
Module: dp_job_issuer

Interface
REQ-001 Parameter N_PARAMS, default 29, number of job parameter words written per job (legal range 1..32).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, accelerator register window base.
REQ-003 Parameter MAX_RETRY, default 16, maximum acquire attempts before error (legal range 1..255).
REQ-004 Parameter EVT_TIMEOUT, default 0, cycles to wait for completion event; 0 disables the timeout.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 job_valid_i  in  1  job descriptor available.
REQ-008 job_params_i  in  N_PARAMS x 32  parameter words, index i written to BASE_ADDR+0x40+4*i.
REQ-009 job_ready_o  out  1  descriptor accepted this cycle.
REQ-010 periph_req_o  out  1  peripheral-master request.
REQ-011 periph_gnt_i  in  1  request granted.
REQ-012 periph_add_o  out  32  byte address.
REQ-013 periph_wen_o  out  1  1 = read, 0 = write.
REQ-014 periph_be_o  out  4  byte enables, always 4'hF.
REQ-015 periph_data_o  out  32  write data.
REQ-016 periph_r_data_i  in  32  read data.
REQ-017 periph_r_valid_i  in  1  read data valid.
REQ-018 evt_i  in  1  accelerator completion event pulse.
REQ-019 busy_o  out  1  job in progress.
REQ-020 done_o  out  1  one-cycle pulse, job completed.
REQ-021 err_o  out  1  one-cycle pulse, job aborted (retry exhausted or timeout).
REQ-022 job_id_o  out  8  low byte of the last acquired job id; valid from entry to WR_PARAM onward.

Function
REQ-023 FSM states: IDLE, ACQ, ACQ_WAIT, WR_PARAM, TRIGGER, WAIT_EVT, FINISH.
REQ-024 IDLE: job_ready_o = 1; on job_valid_i, capture all job_params_i into an internal buffer, clear the retry counter, and go to ACQ.
REQ-025 ACQ: drive a read at BASE_ADDR+0x04 (periph_req_o=1, periph_wen_o=1); on periph_gnt_i, go to ACQ_WAIT.
REQ-026 ACQ_WAIT: periph_req_o = 0; on periph_r_valid_i, handle the read data as follows.
  - Data 32'hFFFF_FFFF = denied: increment the retry counter; if count == MAX_RETRY, pulse err_o and go to IDLE, else go to ACQ.
  - Any other value: latch it into job_id_o, clear the parameter index, and go to WR_PARAM.
REQ-027 WR_PARAM: drive a write of the buffer word at the current index to BASE_ADDR+0x40+4*index; on gnt, increment the index; after index N_PARAMS-1 is granted, go to TRIGGER.
REQ-028 TRIGGER: write 32'h0 to BASE_ADDR+0x00; on gnt, clear the timeout counter and go to WAIT_EVT.
REQ-029 Handshake rules, all peripheral states:
  - periph_req_o is held with stable add/wen/data until periph_gnt_i.
  - Back-to-back writes are allowed on consecutive cycles.
  - No new request is issued while a read response is outstanding.
REQ-030 WAIT_EVT: on evt_i, go to FINISH; if EVT_TIMEOUT != 0 and the counter reaches EVT_TIMEOUT, pulse err_o and go to IDLE.
REQ-031 FINISH: pulse done_o for exactly one cycle, then go to IDLE.
REQ-032 evt_i is ignored in every state except WAIT_EVT (stale events from earlier jobs SHALL NOT complete a job).
REQ-033 busy_o = 1 in every state except IDLE; job_ready_o = 0 whenever busy_o = 1.
REQ-034 job_params_i changes after capture SHALL NOT affect the words written.
REQ-035 periph_r_valid_i outside ACQ_WAIT is ignored.
REQ-036 The retry counter, parameter index and timeout counter SHALL NOT wrap.
REQ-037 Index and counter widths are sized from N_PARAMS, MAX_RETRY and EVT_TIMEOUT.

Reset
REQ-038 On rst_ni low, immediately, including mid-transaction:
  - FSM goes to IDLE.
  - periph_req_o, done_o, err_o, busy_o = 0; job_ready_o = 0 while in reset, 1 after release.
  - periph_add_o, periph_data_o, job_id_o, all counters and the parameter buffer = 0.
  - periph_wen_o = 1; periph_be_o = 4'hF.
REQ-039 After reset release, the first request appears no earlier than one cycle after job_valid_i is sampled.

Verification
REQ-040 Nominal, N_PARAMS=3, gnt always 1, acquire returns 0x05:
  - Stimulus: job {0xA,0xB,0xC}.
  - Response: read 0x04, writes 0x40=0xA, 0x44=0xB, 0x48=0xC, write 0x00=0; job_id_o = 0x05.
  - evt_i 10 cycles later -> done_o one pulse.
REQ-041 Acquire denied twice then granted, MAX_RETRY=4 -> three reads of 0x04, then normal completion; err_o never asserted.
REQ-042 Acquire always 0xFFFF_FFFF, MAX_RETRY=4 -> exactly 4 reads, one err_o pulse, no writes issued, busy_o = 0 after.
REQ-043 Random gnt stalls of 0-5 cycles during WR_PARAM -> address/data held stable while req=1 and not granted; all N_PARAMS words written in order exactly once.
REQ-044 Event ordering: evt_i pulsed during WR_PARAM is ignored; EVT_TIMEOUT=20 with no event after trigger -> err_o pulses 20 cycles after the trigger grant.
REQ-045 rst_ni asserted mid-WR_PARAM with req high -> periph_req_o drops asynchronously; after release, job_ready_o = 1 and a fresh job starts with an acquire read.
